fetch_unit: RTL
===============

# fetch_unit

Instruction fetch and program-counter unit for the RV32I core. Owns the PC register and issues single-outstanding read requests to instruction memory. Presents each fetched instruction to decode through a valid/ready handshake. Consumes the redirect flag produced by the branch unit (`NextPCSrc`) together with the computed target, and discards any stale in-flight fetch on redirect.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC value after reset.
- `NOP_INST`, default 32'h0000_0013: value driven on `Inst` when no instruction is held (ADDI x0,x0,0).

Ports:
- `clk`  in  1  core clock; all state updates on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset. Asserts immediately; deasserts synchronously to `clk` upstream.
- `NextPCSrc`  in  1  redirect request (branch taken or jump); honored in any cycle it is high.
- `BrTarget`  in  32  redirect target; bit 0 is forced to 0 (JALR rule).
- `IMemReq`  out  1  fetch request valid.
- `IMemAddr`  out  32  fetch address; always equals the PC register.
- `IMemGnt`  in  1  memory accepts request this cycle.
- `IMemRValid`  in  1  read data valid (one pulse per granted request, ≥1 cycle after grant).
- `IMemRData`  in  32  read data.
- `InstValid`  out  1  `Inst`/`InstPC` hold a valid instruction.
- `Inst`  out  32  fetched instruction.
- `InstPC`  out  32  address of `Inst`.
- `InstReady`  in  1  decode accepts `Inst` this cycle.
- `MisalignErr`  out  1  sticky instruction-address-misaligned flag.

## Operation
- States: REQ, WAIT, HOLD, ERROR. Reset enters REQ with PC=`RESET_PC`, kill=0.
- REQ:
  - `IMemReq`=1.
  - On `IMemGnt` → WAIT.
  - `IMemAddr` may change while `IMemReq` is high only because of a redirect.
- WAIT:
  - `IMemReq`=0; waits for `IMemRValid`.
  - If kill=0: capture `IMemRData`→`Inst`, PC→`InstPC`, then → HOLD.
  - If kill=1: drop data, clear kill, then → REQ (PC already holds the redirect target).
- HOLD:
  - `InstValid`=1.
  - On `InstReady`: PC←PC+4 (mod 2^32, wraps 32'hFFFF_FFFC→0), then → REQ.
- Redirect (`NextPCSrc`=1), target T={`BrTarget`[31:1],1'b0}. Priority over every other event in the same cycle.
  - If T[1]=1: → ERROR, PC←T, `MisalignErr`←1.
  - REQ without grant: PC←T, stay REQ (request re-issued with new address next cycle).
  - REQ with grant in the same cycle: PC←T, kill←1, → WAIT.
  - WAIT: PC←T, kill←1, stay WAIT. If `IMemRValid` arrives in the same cycle, drop that data and go → REQ.
  - HOLD: PC←T, drop held instruction, → REQ. `InstReady` in the same cycle is ignored; no PC+4.
- ERROR:
  - `IMemReq`=0, `InstValid`=0, `MisalignErr`=1.
  - Left only by reset; further redirects are ignored.
- `InstValid`=0 → `Inst`=`NOP_INST`. `InstPC` holds its last value.
- `IMemRValid` outside WAIT is ignored.

## Timing
- Reset values: `IMemReq`=0 while `rst_n`=0, then 1 in the first cycle after release. `IMemAddr`=`RESET_PC`, `InstValid`=0, `Inst`=`NOP_INST`, `InstPC`=`RESET_PC`, `MisalignErr`=0.
- Reset mid-operation: any in-flight response is forgotten. A later `IMemRValid` from the old request is ignored because the unit is in REQ.
- Latency, zero-wait memory (grant in the first REQ cycle, RValid the next cycle): REQ(c0) → WAIT(c1, RValid) → `InstValid`=1 at c2.
  - Steady throughput with `InstReady` tied high: one instruction per 3 cycles.
- Redirect at edge c: `IMemAddr`=T from c+1. The first instruction from T is valid no earlier than c+3.
- Outputs are registered except `IMemReq`/`InstValid`, which are decoded from state. `Inst` is a register.

## Test plan
- Reset, zero-wait memory returning 32'h0000_0093 at 0 and 32'h0010_0113 at 4, `InstReady`=1 → `InstPC` sequence 0, 4, 8; `Inst` matches memory; `IMemReq` low during reset.
- Backpressure: `InstReady`=0 for 5 cycles in HOLD → `Inst`/`InstPC` stable, `IMemReq`=0, PC unchanged. Then `InstReady`=1 → next fetch at PC+4.
- Redirect in WAIT, `BrTarget`=32'h0000_0101, memory response delayed 3 cycles → old data never appears on `Inst`; next `IMemAddr`=32'h0000_0100.
- Redirect and `InstReady` in the same HOLD cycle, target 32'h40 → next `IMemAddr`=32'h40, not PC+4.
- Redirect to 32'h0000_0022 → `MisalignErr`=1 next cycle; `IMemReq` and `InstValid` stay 0 until `rst_n` pulse, after which fetch restarts at `RESET_PC`.
- Wrap: `RESET_PC`=32'hFFFF_FFFC, accept one instruction → next `IMemAddr`=32'h0000_0000.

Source files
------------

// File: rtl/fetch_unit.sv
// RV32I fetch unit: owns the PC, issues one outstanding instruction read, hands the word to decode via valid/ready.
// Redirects take priority over all other events; a misaligned target parks the unit in ERROR until reset.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        NextPCSrc,
  input  logic [31:0] BrTarget,
  output logic        IMemReq,
  output logic [31:0] IMemAddr,
  input  logic        IMemGnt,
  input  logic        IMemRValid,
  input  logic [31:0] IMemRData,
  output logic        InstValid,
  output logic [31:0] Inst,
  output logic [31:0] InstPC,
  input  logic        InstReady,
  output logic        MisalignErr
);

  typedef enum logic [1:0] {
    S_REQ   = 2'd0,
    S_WAIT  = 2'd1,
    S_HOLD  = 2'd2,
    S_ERROR = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_next_state;
  logic [31:0] r_pc;
  logic [31:0] w_next_pc;
  logic        r_kill;
  logic        w_next_kill;
  logic [31:0] r_inst;
  logic [31:0] r_inst_pc;
  logic        r_misalign;
  logic        w_capture;
  logic        w_set_err;
  logic        w_redirect;
  logic [31:0] w_target;

  assign w_target   = BrTarget & ~32'h0000_0001;
  assign w_redirect = NextPCSrc && (r_state != S_ERROR);

  always_comb begin
    w_next_state = r_state;
    w_next_pc    = r_pc;
    w_next_kill  = r_kill;
    w_capture    = 1'b0;
    w_set_err    = 1'b0;

    if (w_redirect) begin
      w_next_pc = w_target;
      if (w_target[1]) begin
        w_next_state = S_ERROR;
        w_next_kill  = 1'b0;
        w_set_err    = 1'b1;
      end else begin
        unique case (r_state)
          S_REQ: begin
            // A request granted this same cycle is already in flight and must be discarded.
            if (IMemGnt) begin
              w_next_state = S_WAIT;
              w_next_kill  = 1'b1;
            end
          end
          S_WAIT: begin
            if (IMemRValid) begin
              w_next_state = S_REQ;
              w_next_kill  = 1'b0;
            end else begin
              w_next_kill  = 1'b1;
            end
          end
          S_HOLD:  w_next_state = S_REQ;
          default: w_next_state = r_state;
        endcase
      end
    end else begin
      unique case (r_state)
        S_REQ: begin
          if (IMemGnt) w_next_state = S_WAIT;
        end
        S_WAIT: begin
          if (IMemRValid) begin
            if (r_kill) begin
              w_next_state = S_REQ;
              w_next_kill  = 1'b0;
            end else begin
              w_next_state = S_HOLD;
              w_capture    = 1'b1;
            end
          end
        end
        S_HOLD: begin
          if (InstReady) begin
            w_next_pc    = r_pc + 32'd4;
            w_next_state = S_REQ;
          end
        end
        default: w_next_state = r_state;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_REQ;
      r_pc       <= RESET_PC;
      r_kill     <= 1'b0;
      r_inst     <= NOP_INST;
      r_inst_pc  <= RESET_PC;
      r_misalign <= 1'b0;
    end else begin
      r_state <= w_next_state;
      r_pc    <= w_next_pc;
      r_kill  <= w_next_kill;
      if (w_capture) begin
        r_inst    <= IMemRData;
        r_inst_pc <= r_pc;
      end else if (w_next_state != S_HOLD) begin
        // Keep Inst at NOP whenever nothing is presented to decode.
        r_inst <= NOP_INST;
      end
      if (w_set_err) r_misalign <= 1'b1;
    end
  end

  // Request is masked while reset is held, since the reset state is REQ.
  assign IMemReq     = rst_n && (r_state == S_REQ);
  assign IMemAddr    = r_pc;
  assign InstValid   = (r_state == S_HOLD);
  assign Inst        = r_inst;
  assign InstPC      = r_inst_pc;
  assign MisalignErr = r_misalign;

endmodule
